// File: rtl/nonce_sweeper.sv
// nonce_sweeper: upstream job driver for a doublesha core.
//   Accepts a mining job (header template, target, inclusive nonce range),
//   patches each nonce into the header little-endian, launches one double-SHA
//   per nonce, compares the byte-reversed digest against the target and
//   reports every hit. Only one hash is in flight at a time.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   job_valid_i/job_ready_o      job offer handshake (ready only in IDLE)
//   job_header_i/target/nonce_*  job contents, captured on accept
//   abort_i                      cancel the current job
//   sha_start_o/sha_block_o      launch pulse and patched header to doublesha
//   sha_complete_i/sha_hash_i    doublesha completion level and digest
//   hit_valid_o/hit_ready_i      hit report handshake, hit_nonce_o/hit_hash_o
//   done_o                       1-cycle pulse when a job ends
//   busy_o                       high whenever not IDLE
//   hash_count_o                 digests completed this job (saturating)
//   state_o                      current FSM state, for observation
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and
// ready are both high; valid never drops and its payload never changes
// until that transfer has happened.
//
// Build option: define NONCE_SWEEP_STOP_ON_HIT_EN to end the job right
// after the first accepted hit instead of sweeping the whole range.
module nonce_sweeper #(
    parameter int HEADER_W = 640,
    parameter int NONCE_W  = 32,
    parameter int HASH_W   = 256,
    parameter int CNT_W    = 48
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  logic [HEADER_W-1:0] job_header_i,
    input  logic [HASH_W-1:0]   job_target_i,
    input  logic [NONCE_W-1:0]  job_nonce_first_i,
    input  logic [NONCE_W-1:0]  job_nonce_last_i,
    input  logic                abort_i,
    output logic                sha_start_o,
    output logic [HEADER_W-1:0] sha_block_o,
    input  logic                sha_complete_i,
    input  logic [HASH_W-1:0]   sha_hash_i,
    output logic                hit_valid_o,
    input  logic                hit_ready_i,
    output logic [NONCE_W-1:0]  hit_nonce_o,
    output logic [HASH_W-1:0]   hit_hash_o,
    output logic                done_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    hash_count_o,
    output logic [2:0]          state_o
);

`ifdef NONCE_SWEEP_STOP_ON_HIT_EN
    localparam logic STOP_ON_HIT = 1'b1;
`else
    localparam logic STOP_ON_HIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_REPORT = 3'd4,
        S_FINISH = 3'd5,
        S_DRAIN  = 3'd6
    } state_t;

    state_t                     state_q;
    logic [HEADER_W-1:NONCE_W]  tmpl_q;
    logic [HASH_W-1:0]          target_q;
    logic [NONCE_W-1:0]         nonce_q;
    logic [NONCE_W-1:0]         last_q;
    logic [HASH_W-1:0]          hash_q;
    logic [CNT_W-1:0]           count_q;
    logic                       cpl_q;
    logic                       cpl_prev_q;
    logic                       abort_pend_q;

    logic                       cpl_edge;
    logic                       hit_w;
    logic                       last_w;
    logic                       unused_nonce_bits;

    // Reverse byte order: byte 0 of the input becomes the most significant.
    function automatic logic [HASH_W-1:0] hash_byte_rev(input logic [HASH_W-1:0] h);
        logic [HASH_W-1:0] r;
        r = '0;
        for (int i = 0; i < HASH_W / 8; i++) begin
            r[8*i +: 8] = h[HASH_W-8-8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [NONCE_W-1:0] nonce_byte_rev(input logic [NONCE_W-1:0] n);
        logic [NONCE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NONCE_W / 8; i++) begin
            r[8*i +: 8] = n[NONCE_W-8-8*i +: 8];
        end
        return r;
    endfunction

    // The template's own nonce bytes are replaced, never used.
    assign unused_nonce_bits = ^job_header_i[NONCE_W-1:0];

    // Completion is synchronised through cpl_q before edge detection, so a
    // level that is already high when a hash launches is never mistaken
    // for a fresh result; only a 0->1 transition counts.
    assign cpl_edge = cpl_q & ~cpl_prev_q;
    assign hit_w    = (hash_byte_rev(hash_q) <= target_q);
    assign last_w   = (nonce_q == last_q);

    assign sha_block_o  = {tmpl_q, nonce_byte_rev(nonce_q)};
    assign hit_nonce_o  = nonce_q;
    assign hit_hash_o   = hash_q;
    assign hash_count_o = count_q;
    assign job_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign state_o      = state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            tmpl_q       <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            last_q       <= '0;
            hash_q       <= '0;
            count_q      <= '0;
            cpl_q        <= 1'b0;
            cpl_prev_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            sha_start_o  <= 1'b0;
            hit_valid_o  <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            cpl_q       <= sha_complete_i;
            cpl_prev_q  <= cpl_q;
            sha_start_o <= 1'b0;
            done_o      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (job_valid_i) begin
                        tmpl_q       <= job_header_i[HEADER_W-1:NONCE_W];
                        target_q     <= job_target_i;
                        nonce_q      <= job_nonce_first_i;
                        last_q       <= job_nonce_last_i;
                        count_q      <= '0;
                        abort_pend_q <= 1'b0;
                        sha_start_o  <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (abort_i) begin
                        done_o  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cpl_edge) begin
                        hash_q <= sha_hash_i;
                        if (count_q != '1) count_q <= count_q + 1'b1;
                        if (abort_i) begin
                            done_o  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            state_q <= S_CHECK;
                        end
                    end else if (abort_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Let the in-flight hash finish so its completion edge
                    // cannot leak into the next job; the result is dropped.
                    if (cpl_edge) begin
                        done_o  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_CHECK: begin
                    if (abort_i || (!hit_w && last_w)) begin
                        done_o  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (hit_w) begin
                        hit_valid_o <= 1'b1;
                        state_q     <= S_REPORT;
                    end else begin
                        nonce_q     <= nonce_q + 1'b1;
                        sha_start_o <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_REPORT: begin
                    // Abort is remembered but only acted on after the hit
                    // has been accepted.
                    if (abort_i) abort_pend_q <= 1'b1;
                    if (hit_ready_i) begin
                        hit_valid_o <= 1'b0;
                        if (abort_i || abort_pend_q || STOP_ON_HIT || last_w) begin
                            done_o  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            nonce_q     <= nonce_q + 1'b1;
                            sha_start_o <= 1'b1;
                            state_q     <= S_LAUNCH;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
